// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: opcode fields, condition codes
// and the flush-handshake state encoding.
package branch_pkg;

  localparam int DIR_BIT  = 3;
  localparam int COND_MSB = 2;

  localparam logic [COND_MSB:0] COND_ALWAYS = 3'd0;
  localparam logic [COND_MSB:0] COND_NEZ    = 3'd1;
  localparam logic [COND_MSB:0] COND_EQZ    = 3'd2;
  localparam logic [COND_MSB:0] COND_OVF    = 3'd3;
  localparam logic [COND_MSB:0] COND_UNF    = 3'd4;
  localparam logic [COND_MSB:0] COND_NEG    = 3'd5;
  localparam logic [COND_MSB:0] COND_ABS    = 3'd6;
  localparam logic [COND_MSB:0] COND_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch decision and target computation; PC-relative targets wrap
// silently modulo 2^DATA_W.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [COND_MSB:0] cond,
  input  logic [DATA_W-1:0] sOperand,
  input  logic [1:0]        opStat,
  input  logic              dir,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] pOperand,
  output logic              taken,
  output logic [DATA_W-1:0] target
);

  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    taken = 1'b0;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_NEZ:    taken = (sOperand != '0);
      COND_EQZ:    taken = (sOperand == '0);
      COND_OVF:    taken = opStat[1];
      COND_UNF:    taken = opStat[0];
      COND_NEG:    taken = sOperand[DATA_W-1];
      COND_ABS:    taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

  always_comb begin
    target = pOperand;
    if (cond != COND_ABS) begin
      target = dir ? (pc + pOperand) : (pc - pOperand);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: accepts branch ops, registers taken targets, raises a flush
// held until acknowledged, then blocks new ops for a programmable shadow.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int OP_W        = 7,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [OP_W-1:0]   opCode_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] pOperand_i,
  input  logic [DATA_W-1:0] sOperand_i,
  input  logic [1:0]        opStat_i,
  input  logic              flushAck_i,
  output logic              flushBack_o,
  output logic              shouldBranch_o,
  output logic              branchDirection_o,
  output logic [DATA_W-1:0] branchTarget_o,
  output logic [CNT_W-1:0]  takenCount_o
);

  localparam int HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q;
  logic                accept;
  logic                taken;
  logic                fire;
  logic [DATA_W-1:0]   target;
  logic                unused_op_bits;

  // Opcode bits above the direction bit are reserved and deliberately ignored.
  assign unused_op_bits = ^opCode_i[OP_W-1:DIR_BIT+1];

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond_eval (
    .cond     (opCode_i[COND_MSB:0]),
    .sOperand (sOperand_i),
    .opStat   (opStat_i),
    .dir      (opCode_i[DIR_BIT]),
    .pc       (pc_i),
    .pOperand (pOperand_i),
    .taken    (taken),
    .target   (target)
  );

  assign accept = valid_i & ready_o;
  assign fire   = accept & taken;

  always_ff @(posedge clock_i or negedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fire) state_d = ST_FLUSH;
      ST_FLUSH: if (flushAck_i) state_d = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
      ST_HOLD:  if (hold_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == ST_IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      hold_q <= '0;
    end else if (state_q == ST_FLUSH && flushAck_i) begin
      hold_q <= HOLD_W'(HOLD_INIT);
    end else if (state_q == ST_HOLD && hold_q != '0) begin
      hold_q <= hold_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      shouldBranch_o    <= 1'b0;
      flushBack_o       <= 1'b0;
      branchDirection_o <= 1'b0;
      branchTarget_o    <= '0;
      takenCount_o      <= '0;
    end else begin
      shouldBranch_o <= fire;
      if (fire) begin
        flushBack_o       <= 1'b1;
        branchDirection_o <= opCode_i[DIR_BIT];
        branchTarget_o    <= target;
        if (takenCount_o != '1) takenCount_o <= takenCount_o + 1'b1;
      end else if (state_q == ST_FLUSH && flushAck_i) begin
        flushBack_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised next-generation branch unit. Sits between operand fetch and the fetch/PC stage.
- Evaluates conditional/unconditional branch ops against a condition operand and ALU status, and computes the full branch target (PC-relative forward/backward with wrap, or absolute).
- Drives a flush handshake that holds until the front end acknowledges, then blocks new branches for a programmable shadow.
- Keeps a saturating taken-branch counter.

Parameters:
- DATA_W, 16, width of PC, operands and target.
- OP_W, 7, opcode width; only bits [3:0] are decoded, upper bits ignored.
- HOLD_CYCLES, 2, post-flush shadow cycles with ready_o low; 0 = no shadow.
- CNT_W, 8, taken-counter width.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  branch op presented this cycle.
- ready_o  out  1  unit can accept; transfer when valid_i & ready_o.
- opCode_i  in  OP_W  [3] direction (1 = forward), [2:0] condition.
- pc_i  in  DATA_W  PC of the branch op.
- pOperand_i  in  DATA_W  offset, or absolute target.
- sOperand_i  in  DATA_W  condition operand.
- opStat_i  in  2  [1] overflow, [0] underflow.
- flushAck_i  in  1  front end has completed the flush.
- flushBack_o  out  1  flush request, level, held until acknowledged.
- shouldBranch_o  out  1  one-cycle pulse: branchTarget_o valid.
- branchDirection_o  out  1  registered opCode_i[3] of the last taken branch.
- branchTarget_o  out  DATA_W  resolved target.
- takenCount_o  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset: all outputs 0 except ready_o = 1; state IDLE; hold counter 0. Reset mid-FLUSH/HOLD aborts to IDLE immediately; no pending flush survives.
- Condition codes [2:0]:
  - 0 ALWAYS
  - 1 NEZ (sOperand_i != 0)
  - 2 EQZ (sOperand_i == 0)
  - 3 OVF (opStat_i[1])
  - 4 UNF (opStat_i[0])
  - 5 NEG (sOperand_i[DATA_W-1])
  - 6 ABS (always taken, absolute)
  - 7 NEVER
- Target:
  - ABS: pOperand_i.
  - Otherwise, forward: pc_i + pOperand_i; backward: pc_i - pOperand_i.
  - Truncated modulo 2^DATA_W; wrap is silent.
- FSM states: IDLE, FLUSH, HOLD. ready_o = (state == IDLE), combinational from state.
- IDLE, accept cycle N:
  - Not taken: stay IDLE; no outputs change except that shouldBranch_o stays 0. Back-to-back accepts are allowed.
  - Taken: at the end of cycle N register branchTarget_o and branchDirection_o, set shouldBranch_o = 1 and flushBack_o = 1, increment takenCount_o unless all-ones, and go to FLUSH. Latency is one cycle.
- FLUSH:
  - shouldBranch_o returns to 0 after exactly one cycle.
  - flushBack_o stays 1; flushAck_i is sampled each cycle. The earliest ack is in cycle N+1.
  - When ack is seen: flushBack_o = 0. Go to HOLD with counter = HOLD_CYCLES-1, or to IDLE if HOLD_CYCLES == 0.
- HOLD: counter decrements each cycle; go to IDLE when it is 0. ready_o reasserts HOLD_CYCLES cycles after the ack edge.
- Ignored inputs: valid_i while ready_o = 0 (upstream must hold the op). flushAck_i outside FLUSH.
- branchTarget_o and branchDirection_o hold their last taken values until the next taken branch.
- Unused opcode bits [OP_W-1:4] have no effect.

Decomposition:
- branch_pkg contains:
  - condition-code localparams (COND_ALWAYS … COND_NEVER).
  - the state encoding (ST_IDLE, ST_FLUSH, ST_HOLD).
  - the opcode field positions (DIR_BIT = 3, COND_MSB = 2).
- One combinational sub-module, branch_cond_eval (parameter DATA_W):
  - inputs: cond, sOperand, opStat, dir, pc, pOperand.
  - outputs: taken, target.
- The top level holds the FSM, the hold counter, the output registers and the counter.

Test Plan:
- Reset low mid-FLUSH: assert reset_i = 0 while flushBack_o = 1 -> the same cycle, flushBack_o = 0 and ready_o = 1; all outputs 0 after release.
- Forward NEZ taken: pc = 0x0100, pOp = 0x0020, sOp = 5, op = 0x09 -> next cycle shouldBranch_o = 1 for one cycle, target = 0x0120, dir = 1, flushBack_o = 1, takenCount = 1.
- Flush handshake with HOLD_CYCLES = 2: hold flushAck_i low 3 cycles, then high 1 cycle:
  - flushBack_o stays 1 throughout, clearing after the ack edge.
  - ready_o is low through 2 HOLD cycles, then high.
  - valid_i pulses during FLUSH/HOLD are ignored (counter unchanged).
- Backward wrap and ABS:
  - pc = 0x0004, pOp = 0x0010, op = 0x00 (ALWAYS, backward) -> target 0xFFF4.
  - op = 0x06 with pOp = 0xBEEF -> target 0xBEEF.
- Not taken and NEVER: back-to-back accepts of EQZ with sOp = 1, OVF with opStat = 2'b01, and NEVER -> ready_o stays 1, shouldBranch_o/flushBack_o stay 0, target holds its previous value.
- Counter saturation, CNT_W = 2: 5 taken branches, each acked -> takenCount_o 1, 2, 3, 3, 3.
